// File: rtl/fifo_pkg.sv
// Constants shared by the FIFO, its storage and any bench or integrator.
package fifo_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int DEPTH       = 8;
  localparam int ADDR_WIDTH  = $clog2(DEPTH);
  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write port, combinational read port.
module fifo_mem
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO: pointers, occupancy count, flag decode and the
// registered data_out; storage lives in fifo_mem.
module sync_fifo
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  PTR_ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] count_next;
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   wr_ok;
  logic                   rd_ok;
  logic                   mem_we;

  // Flags depend only on registered count, so both requests see pre-edge state.
  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);
  assign wr_ok = write_en & ~full;
  assign rd_ok = read_en & ~empty;

  // A write coinciding with reset must not land in storage.
  assign mem_we = wr_ok & ~reset;

  fifo_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_comb begin
    count_next = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count + COUNT_ONE;
      2'b01:   count_next = count - COUNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      count <= count_next;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus updates a queue model and posts
// expected outputs; an independent monitor compares them on the falling edge.
module tb_sync_fifo;
  import fifo_pkg::*;

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    logic                  empty;
    logic                  full;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t                  exp_q[$];
  logic [DATA_WIDTH-1:0] model_q[$];
  logic [DATA_WIDTH-1:0] last_out;

  sync_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle, then advance the queue model using the pre-edge occupancy.
  task automatic applyStimulus(input logic rst, input logic we, input logic re,
                               input logic [DATA_WIDTH-1:0] d);
    exp_t e;
    int   occ;
    reset    = rst;
    write_en = we;
    read_en  = re;
    data_in  = d;
    @(posedge clk);
    occ = model_q.size();
    if (rst) begin
      model_q.delete();
      last_out = '0;
    end else begin
      if (re && occ != 0) last_out = model_q.pop_front();
      if (we && occ != DEPTH) model_q.push_back(d);
    end
    e.data  = last_out;
    e.empty = (model_q.size() == 0);
    e.full  = (model_q.size() == DEPTH);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("data_out", data_out, e.data);
      checkOutput("empty", {7'b0, empty}, {7'b0, e.empty});
      checkOutput("full", {7'b0, full}, {7'b0, e.full});
    end
  end

  initial begin
    last_out = '0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Fill, overflow attempt, drain, underflow attempt
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'(i));
    applyStimulus(0, 1, 0, 8'd99);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 8'(i + 10));
      applyStimulus(0, 0, 1, 0);
    end

    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 8'(i + 20));
    applyStimulus(0, 0, 1, 0);

    // Wrap the pointers past the end of storage
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'(i + 30));
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'(i + 40));
    applyStimulus(0, 1, 1, 8'd77);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0);

    applyStimulus(0, 1, 0, 8'd55);
    applyStimulus(1, 1, 0, 8'd56);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);

    // Random phases biased towards filling, draining, then balanced
    for (int i = 0; i < 300; i++) begin
      int wp;
      int rp;
      wp = (i < 100) ? 75 : (i < 200) ? 25 : 50;
      rp = 100 - wp;
      applyStimulus(0, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                    8'($urandom));
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
